// File: rtl/sign_ext_pkg.sv
// rtl/sign_ext_pkg.sv - RV32I opcode constants and immediate format enum
package sign_ext_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } imm_fmt_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode to immediate format decode and extraction
module imm_decode
  import sign_ext_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [31:7] inst,
  output logic [31:0] imm,
  output imm_fmt_t    fmt,
  output logic        illegal
);

  // Unlisted or unknown opcodes fall to the default arm, so nothing undefined reaches the registers.
  always_comb begin
    imm     = 32'h0000_0000;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
        imm     = {{20{inst[31]}}, inst[31:20]};
        fmt     = FMT_I;
        illegal = 1'b0;
      end
      OPC_STORE: begin
        imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        fmt     = FMT_S;
        illegal = 1'b0;
      end
      OPC_BRANCH: begin
        imm     = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        fmt     = FMT_B;
        illegal = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm     = {inst[31:12], 12'h000};
        fmt     = FMT_U;
        illegal = 1'b0;
      end
      OPC_JAL: begin
        imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        fmt     = FMT_J;
        illegal = 1'b0;
      end
      default: begin
        imm     = 32'h0000_0000;
        fmt     = FMT_NONE;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - registered RV32I immediate generator, one cycle latency
module sign_extender
  import sign_ext_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [31:0] inst_in,
  output logic [31:0] imm_out,
  output logic [2:0]  imm_fmt,
  output logic        illegal,
  output logic        out_valid
);

  logic [31:0] dec_imm;
  imm_fmt_t    dec_fmt;
  logic        dec_illegal;

  // The opcode arrives on its own port, so the low instruction bits are never consulted.
  logic unused_inst_lo;
  assign unused_inst_lo = &{1'b0, inst_in[6:0]};

  imm_decode u_imm_decode (
    .opcode  (opcode),
    .inst    (inst_in[31:7]),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_out   <= 32'h0000_0000;
      imm_fmt   <= FMT_R;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm_out <= dec_imm;
        imm_fmt <= dec_fmt;
        illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_sign_extender.sv
// tb/tb_sign_extender.sv - table-driven self-checking bench for sign_extender
module tb_sign_extender;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  opcode;
  logic [31:0] inst_in;
  logic [31:0] imm_out;
  logic [2:0]  imm_fmt;
  logic        illegal;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  sign_extender dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .inst_in   (inst_in),
    .imm_out   (imm_out),
    .imm_fmt   (imm_fmt),
    .illegal   (illegal),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [31:0] inst;
    logic [31:0] exp_imm;
    logic [2:0]  exp_fmt;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{7'b0110011, 32'h01190933, 32'h00000000, 3'd0, 1'b0};
    vecs[1]  = '{7'b0010011, 32'hfffb8b93, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[2]  = '{7'b1100111, 32'h7ff080e7, 32'h000007FF, 3'd1, 1'b0};
    vecs[3]  = '{7'b0000011, 32'h0002a303, 32'h00000000, 3'd1, 1'b0};
    vecs[4]  = '{7'b0100011, 32'h0082a223, 32'h00000004, 3'd2, 1'b0};
    vecs[5]  = '{7'b1100011, 32'h014c6463, 32'h00000008, 3'd3, 1'b0};
    vecs[6]  = '{7'b0110111, 32'h872370b7, 32'h87237000, 3'd4, 1'b0};
    vecs[7]  = '{7'b0010111, 32'h10000917, 32'h10000000, 3'd4, 1'b0};
    vecs[8]  = '{7'b1101111, 32'h0000006f, 32'h00000000, 3'd5, 1'b0};
    vecs[9]  = '{7'b1101111, 32'hfe1ff06f, 32'hFFFFFFE0, 3'd5, 1'b0};
    vecs[10] = '{7'b1100011, 32'h80000063, 32'hFFFFF000, 3'd3, 1'b0};
    vecs[11] = '{7'b0100011, 32'hfe000fa3, 32'hFFFFFFFF, 3'd2, 1'b0};
    vecs[12] = '{7'b1110011, 32'h80000073, 32'hFFFFF800, 3'd1, 1'b0};
    vecs[13] = '{7'b0001111, 32'h0ff0000f, 32'h000000FF, 3'd1, 1'b0};
    // opcode port overrides inst_in[6:0]
    vecs[14] = '{7'b0110111, 32'habcde033, 32'hABCDE000, 3'd4, 1'b0};
    vecs[15] = '{7'b1111111, 32'hfe1ff06f, 32'h00000000, 3'd6, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    opcode   = 7'd0;
    inst_in  = 32'h0;
    step();
    step();
    check("reset_imm", imm_out, 32'h0);
    check("reset_fmt", {29'd0, imm_fmt}, 32'd0);
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_valid", {31'd0, out_valid}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = vecs[k].opc;
      inst_in  = vecs[k].inst;
      #1;
      check($sformatf("pre_edge_imm[%0d]", k), imm_out,
            (k == 0) ? 32'h0 : vecs[k-1].exp_imm);
      step();
      check($sformatf("imm[%0d]", k), imm_out, vecs[k].exp_imm);
      check($sformatf("fmt[%0d]", k), {29'd0, imm_fmt}, {29'd0, vecs[k].exp_fmt});
      check($sformatf("illegal[%0d]", k), {31'd0, illegal}, {31'd0, vecs[k].exp_ill});
      check($sformatf("valid[%0d]", k), {31'd0, out_valid}, 32'd1);
    end

    // hold: in_valid low with a new instruction presented
    @(negedge clk);
    in_valid = 1'b0;
    opcode   = 7'b0010011;
    inst_in  = 32'hfffb8b93;
    step();
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_imm", imm_out, 32'h0);
    check("hold_fmt", {29'd0, imm_fmt}, 32'd6);
    check("hold_illegal", {31'd0, illegal}, 32'd1);
    step();
    check("hold2_fmt", {29'd0, imm_fmt}, 32'd6);

    // load a nonzero result, then reset while in_valid is high
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 7'b0110111;
    inst_in  = 32'h872370b7;
    step();
    check("preload_imm", imm_out, 32'h87237000);
    @(negedge clk);
    rst_n   = 1'b0;
    opcode  = 7'b1111111;
    step();
    check("rst_win_imm", imm_out, 32'h0);
    check("rst_win_fmt", {29'd0, imm_fmt}, 32'd0);
    check("rst_win_illegal", {31'd0, illegal}, 32'd0);
    check("rst_win_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
